// File: rtl/zint_sched_pkg.sv
// Shared definitions for the Z80 /INT scheduler: FSM states and default timing/vector parameters.
package zint_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_ACK,
        S_GAP
    } state_t;

    localparam int unsigned DEF_INT_LEN  = 128;
    localparam int unsigned DEF_GAP      = 16;
    localparam logic [7:0]  DEF_VEC_BASE = 8'hF0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zint_prio_enc.sv
// Lowest-index-first priority encoder: valid when any request is set, idx of the lowest set bit.
module zint_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/zint_sched.sv
// Z80 /INT scheduler: latches per-source requests, grants one at a time by fixed priority,
// holds /INT low until acknowledge or timeout, then enforces a minimum high gap.
module zint_sched
    import zint_sched_pkg::*;
#(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned INT_LEN  = DEF_INT_LEN,
    parameter int unsigned GAP      = DEF_GAP,
    parameter logic [7:0]  VEC_BASE = DEF_VEC_BASE
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             zpos,
    input  logic             zneg,
    input  logic             iorq_n,
    input  logic             m1_n,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] en,
    input  logic [N_SRC-1:0] missed_clr,
    output logic             int_n,
    output logic [7:0]       vec,
    output logic             vec_oe,
    output logic [2:0]       cur_src,
    output logic [N_SRC-1:0] missed
);

    localparam int unsigned CW = $clog2(max_u(INT_LEN, GAP) + 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [N_SRC-1:0] pend, pend_d, missed_d;
    logic [N_SRC-1:0] cand, cur_mask, clr, set;
    logic             int_n_d, vec_oe_d;
    logic [7:0]       vec_d;
    logic [2:0]       cur_src_d;
    logic             grant_valid;
    logic [2:0]       grant_idx;
    logic             ack;
    logic             zpos_unused;

    // zpos is reserved for future bus-phase alignment
    assign zpos_unused = zpos;
    assign ack         = !iorq_n && !m1_n && zneg;
    assign cand        = pend & en;

    zint_prio_enc #(.N(N_SRC)) u_prio_enc (
        .req   (cand),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

    always_comb begin
        cur_mask = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cur_mask[i] = (cur_src == 3'(i));
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        int_n_d   = int_n;
        vec_d     = vec;
        vec_oe_d  = vec_oe;
        cur_src_d = cur_src;
        clr       = '0;
        set       = '0;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    cur_src_d = grant_idx;
                    vec_d     = VEC_BASE + {4'b0000, grant_idx, 1'b0};
                    int_n_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_ASSERT;
                end
            end
            S_ASSERT: begin
                cnt_d = cnt + CW'(1);
                // acknowledge takes precedence over a timeout landing in the same cycle
                if (ack) begin
                    int_n_d  = 1'b1;
                    vec_oe_d = 1'b1;
                    clr      = cur_mask;
                    state_d  = S_ACK;
                end else if (cnt == CW'(INT_LEN - 1)) begin
                    int_n_d = 1'b1;
                    clr     = cur_mask;
                    set     = cur_mask;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_ACK: begin
                if (iorq_n) begin
                    vec_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // new requests and new misses win over same-cycle clears
        pend_d   = (pend & ~clr) | req;
        missed_d = (missed & ~missed_clr) | set;
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            int_n   <= 1'b1;
            vec     <= VEC_BASE;
            vec_oe  <= 1'b0;
            cur_src <= '0;
            pend    <= '0;
            missed  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            int_n   <= int_n_d;
            vec     <= vec_d;
            vec_oe  <= vec_oe_d;
            cur_src <= cur_src_d;
            pend    <= pend_d;
            missed  <= missed_d;
        end
    end

endmodule

// File: tb/tb_zint_sched.sv
// Bench for zint_sched: directed scenarios then random traffic, every cycle compared to a
// timestamp-based reference model of the grant/acknowledge/gap rules.
module tb_zint_sched;

    localparam int unsigned NS = 4;
    localparam int unsigned IL = 128;
    localparam int unsigned GP = 16;
    localparam logic [7:0]  VB = 8'hF0;

    logic          fclk = 1'b0;
    logic          rst, zpos, zneg, iorq_n, m1_n;
    logic [NS-1:0] req, en, missed_clr;
    logic          int_n, vec_oe;
    logic [7:0]    vec;
    logic [2:0]    cur_src;
    logic [NS-1:0] missed;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: grant edge timestamp and earliest next arbitration edge
    int            now = 0;
    int            m_g = 0;
    int            m_free = 0;
    bit            m_low = 1'b0;
    bit            m_oe = 1'b0;
    bit [NS-1:0]   m_pend = '0;
    bit [NS-1:0]   m_missed = '0;
    logic [7:0]    m_vec = VB;
    logic [2:0]    m_cur = '0;

    zint_sched #(.N_SRC(NS), .INT_LEN(IL), .GAP(GP), .VEC_BASE(VB)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .zpos       (zpos),
        .zneg       (zneg),
        .iorq_n     (iorq_n),
        .m1_n       (m1_n),
        .req        (req),
        .en         (en),
        .missed_clr (missed_clr),
        .int_n      (int_n),
        .vec        (vec),
        .vec_oe     (vec_oe),
        .cur_src    (cur_src),
        .missed     (missed)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [NS-1:0] clr, set, cand;
        bit          ack;
        now++;
        if (rst) begin
            m_low = 0; m_oe = 0; m_pend = '0; m_missed = '0;
            m_vec = VB; m_cur = '0; m_free = now + 1;
            return;
        end
        ack  = !iorq_n && !m1_n && zneg;
        clr  = '0;
        set  = '0;
        cand = m_pend & en;
        if (m_low) begin
            if (ack) begin
                m_low = 0; m_oe = 1; clr[m_cur] = 1'b1;
            end else if (now - m_g == int'(IL)) begin
                m_low = 0; clr[m_cur] = 1'b1; set[m_cur] = 1'b1;
                m_free = now + int'(GP) + 1;
            end
        end else if (m_oe) begin
            if (iorq_n) begin
                m_oe = 0; m_free = now + int'(GP) + 1;
            end
        end else if (now >= m_free && cand != '0) begin
            for (int i = 0; i < int'(NS); i++) begin
                if (cand[i]) begin
                    m_cur = 3'(i);
                    m_vec = VB + 8'(2 * i);
                    m_low = 1;
                    m_g   = now;
                    break;
                end
            end
        end
        m_pend   = (m_pend & ~clr) | req;
        m_missed = (m_missed & ~missed_clr) | set;
    endtask

    task automatic tick();
        @(posedge fclk);
        model_step();
        #1;
        chk("int_n", {31'b0, int_n}, {31'b0, !m_low});
        chk("vec_oe", {31'b0, vec_oe}, {31'b0, m_oe});
        chk("vec", {24'b0, vec}, {24'b0, m_vec});
        chk("cur_src", {29'b0, cur_src}, {29'b0, m_cur});
        chk("missed", {28'b0, missed}, {28'b0, m_missed});
    endtask

    task automatic do_ack();
        iorq_n = 0; m1_n = 0; zneg = 1;
        tick();
        zneg = 0;
        tick();
        iorq_n = 1; m1_n = 1;
        tick();
    endtask

    initial begin
        int cnt;
        rst = 1; zpos = 0; zneg = 0; iorq_n = 1; m1_n = 1;
        req = '0; en = '0; missed_clr = '0;
        tick(); tick();
        rst = 0;
        chk("rst_int_n", {31'b0, int_n}, 32'd1);
        chk("rst_vec", {24'b0, vec}, 32'hF0);
        tick();

        // 1: single request, ack after 10 cycles
        en = 4'hF; req = 4'b0001; tick(); req = '0;
        tick();
        chk("s1_int_low", {31'b0, int_n}, 32'd0);
        chk("s1_vec", {24'b0, vec}, 32'hF0);
        repeat (8) tick();
        iorq_n = 0; m1_n = 0; zneg = 1; tick(); zneg = 0;
        chk("s1_oe", {31'b0, vec_oe}, 32'd1);
        repeat (3) tick();
        chk("s1_oe_hold", {31'b0, vec_oe}, 32'd1);
        iorq_n = 1; m1_n = 1; tick();
        chk("s1_oe_drop", {31'b0, vec_oe}, 32'd0);
        repeat (GP + 4) tick();
        chk("s1_no_regrant", {31'b0, int_n}, 32'd1);

        // 2: timeout of src2, then clear missed
        req = 4'b0100; tick(); req = '0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (int_n === 1'b0) cnt++;
            else if (cnt > 0) break;
        end
        chk("s2_low_len", cnt, IL);
        chk("s2_missed", {28'b0, missed}, 32'b0100);
        repeat (GP + 2) tick();
        missed_clr = 4'b0100; tick(); missed_clr = '0;
        chk("s2_missed_clr", {28'b0, missed}, 32'd0);

        // 3: simultaneous src3 and src1 requests
        req = 4'b1010; tick(); req = '0;
        tick();
        chk("s3_first_vec", {24'b0, vec}, 32'hF2);
        do_ack();
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cnt++;
            if (int_n === 1'b0) break;
        end
        chk("s3_wait", cnt, GP + 1);
        chk("s3_second_vec", {24'b0, vec}, 32'hF6);
        do_ack();
        repeat (GP + 2) tick();

        // 4: masked request becomes visible when enabled
        en = 4'b1101; req = 4'b0010; tick(); req = '0;
        repeat (20) tick();
        chk("s4_blocked", {31'b0, int_n}, 32'd1);
        en = 4'hF; tick();
        chk("s4_grant", {31'b0, int_n}, 32'd0);
        chk("s4_src", {29'b0, cur_src}, 32'd1);
        do_ack();
        repeat (GP + 2) tick();

        // 5: ack on the timeout cycle plus re-request on the clear cycle
        req = 4'b0001; tick(); req = '0;
        tick();
        repeat (IL - 1) tick();
        chk("s5_still_low", {31'b0, int_n}, 32'd0);
        iorq_n = 0; m1_n = 0; zneg = 1; req = 4'b0001; tick(); zneg = 0; req = '0;
        chk("s5_acked", {31'b0, vec_oe}, 32'd1);
        chk("s5_no_missed", {28'b0, missed}, 32'd0);
        iorq_n = 1; m1_n = 1; tick();
        repeat (GP) tick();
        chk("s5_gap_high", {31'b0, int_n}, 32'd1);
        tick();
        chk("s5_regrant", {31'b0, int_n}, 32'd0);
        do_ack();
        repeat (GP + 2) tick();

        // 6: reset mid-grant and during vector drive
        req = 4'b1000; tick(); req = '0;
        repeat (IL + GP + 4) tick();
        chk("s6_missed_set", {28'b0, missed}, 32'b1000);
        en = 4'b1011; req = 4'b0110; tick(); req = '0;
        tick();
        chk("s6_low", {31'b0, int_n}, 32'd0);
        rst = 1; tick(); rst = 0;
        chk("s6_rst_int", {31'b0, int_n}, 32'd1);
        chk("s6_rst_missed", {28'b0, missed}, 32'd0);
        en = 4'hF;
        repeat (GP + 4) tick();
        chk("s6_pend_dropped", {31'b0, int_n}, 32'd1);
        req = 4'b0001; tick(); req = '0; tick();
        iorq_n = 0; m1_n = 0; zneg = 1; tick(); zneg = 0;
        chk("s6_oe_before", {31'b0, vec_oe}, 32'd1);
        rst = 1; tick(); rst = 0; iorq_n = 1; m1_n = 1;
        chk("s6_rst_oe", {31'b0, vec_oe}, 32'd0);
        tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            req        = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(0, 49) == 0) en = 4'($urandom);
            zneg       = ($urandom_range(0, 3) == 0);
            zpos       = 1'($urandom_range(0, 1));
            iorq_n     = ($urandom_range(0, 2) != 0);
            m1_n       = ($urandom_range(0, 2) != 0);
            missed_clr = ($urandom_range(0, 29) == 0) ? 4'($urandom) : '0;
            rst        = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
